ecc_resp_tx: RTL and testbench
==============================

# ecc_resp_tx

Bit-serial response transmitter for the ECC authentication path. It captures the 163-bit ECC result when the ECC controller signals completion, appends a CRC-16, and hands the 179-bit frame to the backscatter encoder one bit per encoder request. It is the outbound counterpart of the controller's inbound basepoint and key shifting, and sits between the ECC core/controller and the encoder.

## Interface
Parameters:
- RESULT_W, 163, width of the ECC result field.
- CRC_W, 16, width of the appended CRC; the CRC function is fixed to CCITT (poly 0x1021).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_time_up  in  1  session timeout; aborts any frame.
- i_done_ECC  in  1  one-cycle completion pulse from the ECC controller; result valid in the same cycle.
- i_result  in  RESULT_W  ECC result (x-coordinate), sampled only on an accepted i_done_ECC.
- i_bit_req_enc  in  1  encoder consumes the currently presented bit this cycle.
- o_tx_req  out  1  frame loaded and bits pending; the encoder may request.
- o_data_enc  out  1  currently presented bit.
- o_last_bit  out  1  the presented bit is bit 179 (the final CRC bit).
- o_tx_done  out  1  one-cycle pulse after the final bit is consumed.

## Operation
- States: IDLE, SEND_DATA, SEND_CRC, DONE.
- IDLE
  - i_done_ECC=1 and i_time_up=0: at the next edge, load data_sh ← i_result, crc ← 16'hFFFF, cnt ← 0, go to SEND_DATA.
  - Otherwise remain in IDLE.
- SEND_DATA
  - o_data_enc = data_sh[162], sent MSB first.
  - On each i_bit_req_enc:
    - b = data_sh[162]; fb = crc[15]^b.
    - crc ← {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
    - data_sh shifts left by 1; cnt increments.
  - Request with cnt==162 (bit 163 consumed): load crc_sh ← ~crc_next (the updated value, inverted), cnt ← 0, go to SEND_CRC.
- SEND_CRC
  - o_data_enc = crc_sh[15].
  - Each request shifts crc_sh left by 1 and increments cnt.
  - o_last_bit = (cnt==15).
  - Request with cnt==15: go to DONE.
- DONE: o_tx_done=1 for exactly one cycle, then IDLE.
- o_tx_req = 1 in SEND_DATA and SEND_CRC, 0 otherwise. o_data_enc = 0 and o_last_bit = 0 outside the send states.
- Counter is 8 bits. It never wraps within a frame (maximum value 162).
- Boundary conditions:
  - i_bit_req_enc with o_tx_req=0: ignored, no state change.
  - i_done_ECC while not in IDLE: ignored; the in-flight frame is untouched.
  - i_done_ECC and i_time_up in the same cycle in IDLE: i_time_up wins, nothing captured.
  - i_time_up in any state: next state IDLE, cnt cleared, o_tx_req low next cycle, no o_tx_done pulse. Stale data_sh and crc contents are harmless.
  - i_time_up in DONE: the o_tx_done already visible that cycle stands; return to IDLE.
  - rst has priority over everything, including i_time_up.

## Timing
- Reset values: state IDLE, cnt 0, crc 16'hFFFF, data_sh 0, crc_sh 0. All outputs 0.
- Capture latency: i_done_ECC sampled at edge N → o_tx_req=1 and o_data_enc=i_result[162] valid after edge N.
- Per-bit handshake: o_data_enc is stable while i_bit_req_enc=0. After a request at edge k, the next bit is valid in the cycle following edge k.
- Requests may be back-to-back every cycle or have arbitrary gaps.
- Exactly 179 accepted requests per frame.
- Done timing: the request on bit 179 at edge k → DONE after edge k (o_tx_done=1, o_tx_req=0) → IDLE after edge k+1.
- Earliest next capture is at the edge where the state is already IDLE: i_done_ECC must be sampled in IDLE, i.e. at edge k+2 or later.
- No combinational path from i_bit_req_enc to any output; all outputs decode from registers.

## Test plan
- Back-to-back frame: i_result=163'h1, continuous requests.
  - Bits 1–162 are 0 and bit 163 is 1.
  - o_last_bit is high only on bit 179.
  - o_tx_done pulses once, one cycle after bit 179 is consumed.
- CRC check with random i_result and random request gaps:
  - The first 163 bits equal i_result MSB-first.
  - A receiver CRC-16 (preset FFFF) run over all 179 received bits ends at residue 16'h1D0F.
  - Repeat for i_result=0 and for all-ones.
- Timeout mid-data: i_time_up after 50 consumed bits.
  - o_tx_req=0 next cycle; no o_tx_done.
  - A following i_done_ECC with 163'h5A… restarts cleanly from its MSB.
- Ignored events:
  - i_done_ECC pulsed during SEND_CRC leaves the in-flight bits unchanged.
  - i_bit_req_enc pulsed in IDLE produces no output change.
- Simultaneous and reset cases:
  - i_done_ECC+i_time_up in IDLE: no capture, o_tx_req stays 0.
  - rst asserted during SEND_DATA: next cycle all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/ecc_resp_tx.sv
// ecc_resp_tx: serialises a captured ECC result plus inverted CRC-16 (CCITT) to the encoder, one bit per request.
module ecc_resp_tx #(
  parameter int RESULT_W = 163,
  parameter int CRC_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_time_up,
  input  logic                i_done_ECC,
  input  logic [RESULT_W-1:0] i_result,
  input  logic                i_bit_req_enc,
  output logic                o_tx_req,
  output logic                o_data_enc,
  output logic                o_last_bit,
  output logic                o_tx_done
);
  typedef enum logic [1:0] {IDLE, SEND_DATA, SEND_CRC, DONE} state_t;
  state_t              state;
  logic [7:0]          cnt;
  logic [CRC_W-1:0]    crc, crc_next, crc_sh;
  logic [RESULT_W-1:0] data_sh;
  logic                fb;
  always_comb begin
    fb       = crc[CRC_W-1] ^ data_sh[RESULT_W-1];
    crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_W'(16'h1021) : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      crc     <= '1;
      data_sh <= '0;
      crc_sh  <= '0;
    end else if (i_time_up) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (i_done_ECC) begin
          data_sh <= i_result;
          crc     <= '1;
          cnt     <= '0;
          state   <= SEND_DATA;
        end
        SEND_DATA: if (i_bit_req_enc) begin
          crc     <= crc_next;
          data_sh <= {data_sh[RESULT_W-2:0], 1'b0};
          cnt     <= cnt + 8'd1;
          if (cnt == 8'(RESULT_W - 1)) begin
            crc_sh <= ~crc_next;
            cnt    <= '0;
            state  <= SEND_CRC;
          end
        end
        SEND_CRC: if (i_bit_req_enc) begin
          crc_sh <= {crc_sh[CRC_W-2:0], 1'b0};
          cnt    <= cnt + 8'd1;
          if (cnt == 8'(CRC_W - 1)) state <= DONE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
  // outputs decode purely from registered state, never from the request input
  always_comb begin
    o_tx_req   = (state == SEND_DATA) || (state == SEND_CRC);
    o_data_enc = (state == SEND_DATA) ? data_sh[RESULT_W-1] : (state == SEND_CRC) ? crc_sh[CRC_W-1] : 1'b0;
    o_last_bit = (state == SEND_CRC) && (cnt == 8'(CRC_W - 1));
    o_tx_done  = (state == DONE);
  end
endmodule

// File: tb/tb_ecc_resp_tx.sv
// tb_ecc_resp_tx: randomized frame checks against a receiver-side CRC model and frame scoreboard.
module tb_ecc_resp_tx;
  logic         clk = 0, rst = 1, i_time_up = 0, i_done_ECC = 0, i_bit_req_enc = 0;
  logic [162:0] i_result = '0;
  logic         o_tx_req, o_data_enc, o_last_bit, o_tx_done;
  int           tests = 0, fails = 0;
  ecc_resp_tx dut (
    .clk(clk), .rst(rst), .i_time_up(i_time_up), .i_done_ECC(i_done_ECC),
    .i_result(i_result), .i_bit_req_enc(i_bit_req_enc), .o_tx_req(o_tx_req),
    .o_data_enc(o_data_enc), .o_last_bit(o_last_bit), .o_tx_done(o_tx_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // CRC-16 CCITT, preset FFFF, over the top n bits of v, MSB first
  function automatic logic [15:0] crc_top(input logic [178:0] v, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 178; i > 178 - n; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
  task automatic check_idle_outputs(input string nm);
    tests++;
    if ({o_tx_req, o_data_enc, o_last_bit, o_tx_done} !== 4'b0) begin
      fails++;
      $display("FAIL %s: outputs req/data/last/done=%b want 0000", nm, {o_tx_req, o_data_enc, o_last_bit, o_tx_done});
    end
  endtask
  task automatic run_frame(input logic [162:0] r, input bit gaps, input int inj, input string nm);
    logic [178:0] rx = '0;
    logic [15:0]  exp_crc;
    int  n = 0, cyc = 0;
    bit  inj_done = 0, bad_last = 0, bad_req = 0, bad_done = 0;
    i_result = r;
    i_done_ECC = 1;
    step();
    i_done_ECC = 0;
    tests++;
    if (o_tx_req !== 1'b1 || o_data_enc !== r[162]) begin
      fails++;
      $display("FAIL %s capture: req=%b data=%b want 1 %b", nm, o_tx_req, o_data_enc, r[162]);
    end
    while (n < 179 && cyc < 4000) begin
      if (o_tx_req !== 1'b1) begin
        bad_req = 1;
        break;
      end
      if (o_last_bit !== (n == 178)) bad_last = 1;
      if (o_tx_done !== 1'b0) bad_done = 1;
      i_done_ECC = (n == inj) && !inj_done;
      if (i_done_ECC) begin
        inj_done = 1;
        i_result = ~r;
      end
      i_bit_req_enc = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i_bit_req_enc) begin
        rx[178-n] = o_data_enc;
        n++;
      end
      step();
      cyc++;
    end
    i_bit_req_enc = 0;
    i_done_ECC = 0;
    exp_crc = ~crc_top({r, 16'h0}, 163);
    tests++;
    if (bad_req || n != 179) begin
      fails++;
      $display("FAIL %s tx_req: dropped after %0d bits, want 179", nm, n);
    end
    tests++;
    if (bad_last) begin
      fails++;
      $display("FAIL %s last_bit: asserted off bit 179 or missing on it", nm);
    end
    tests++;
    if (bad_done) begin
      fails++;
      $display("FAIL %s tx_done: pulsed mid-frame", nm);
    end
    tests++;
    if (rx[178:16] !== r) begin
      fails++;
      $display("FAIL %s data: got %h want %h", nm, rx[178:16], r);
    end
    tests++;
    if (rx[15:0] !== exp_crc) begin
      fails++;
      $display("FAIL %s crc: got %h want %h", nm, rx[15:0], exp_crc);
    end
    tests++;
    if (crc_top(rx, 179) !== 16'h1D0F) begin
      fails++;
      $display("FAIL %s residue: got %h want 1d0f", nm, crc_top(rx, 179));
    end
    tests++;
    if (o_tx_done !== 1'b1 || o_tx_req !== 1'b0) begin
      fails++;
      $display("FAIL %s done: done=%b req=%b want 1 0", nm, o_tx_done, o_tx_req);
    end
    step();
    check_idle_outputs({nm, " after done"});
  endtask
  task automatic consume(input int k);
    for (int i = 0; i < k; i++) begin
      i_bit_req_enc = 1;
      step();
    end
    i_bit_req_enc = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    check_idle_outputs("reset");
    rst = 0;
    step();
    check_idle_outputs("post reset");
  endtask
  task automatic test_back_to_back();
    run_frame(163'h1, 0, -1, "b2b_one");
  endtask
  task automatic test_crc_random();
    logic [162:0] r;
    for (int t = 0; t < 4; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_frame(r, 1, -1, "crc_rand");
    end
    run_frame('0, 1, -1, "crc_zero");
    run_frame('1, 1, -1, "crc_ones");
  endtask
  task automatic test_timeout();
    logic [167:0] p = {21{8'h5A}};
    bit saw_done = 0;
    i_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    i_done_ECC = 1;
    step();
    i_done_ECC = 0;
    consume(50);
    i_time_up = 1;
    step();
    i_time_up = 0;
    check_idle_outputs("timeout");
    for (int i = 0; i < 4; i++) begin
      if (o_tx_done !== 1'b0 || o_tx_req !== 1'b0) saw_done = 1;
      step();
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL timeout quiet: done/req seen after abort, want 0");
    end
    run_frame(p[167:5], 1, -1, "timeout_restart");
  endtask
  task automatic test_ignored();
    run_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 168, "done_in_crc");
    run_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 0, 20, "done_in_data");
    for (int i = 0; i < 3; i++) begin
      i_bit_req_enc = 1;
      step();
      check_idle_outputs("req_in_idle");
    end
    i_bit_req_enc = 0;
  endtask
  task automatic test_simultaneous();
    i_result = '1;
    i_done_ECC = 1;
    i_time_up = 1;
    step();
    i_done_ECC = 0;
    i_time_up = 0;
    check_idle_outputs("done_with_timeup");
    step();
    check_idle_outputs("done_with_timeup+1");
  endtask
  task automatic test_rst_mid();
    i_result = '1;
    i_done_ECC = 1;
    step();
    i_done_ECC = 0;
    consume(20);
    rst = 1;
    i_time_up = 1;
    step();
    rst = 0;
    i_time_up = 0;
    check_idle_outputs("rst_mid");
    consume(2);
    check_idle_outputs("rst_mid idle");
    run_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, -1, "after_rst");
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_crc_random();
    test_timeout();
    test_ignored();
    test_simultaneous();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
